uart_cpld_responder: RTL and testbench

//  Device-side UART responder for the CPU's memory unit. It answers the active-low rdn/wrn strobes
//  and the 8-bit shared data-bus protocol issued by the memory unit, and reports dataready/tbre/tsre.
//  It serialises and deserialises bytes on txd/rxd in 8N1 format. It replaces the external UART

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_cpld_responder_if.sv | 23 ++
 rtl/uart_rx_deserializer.sv | 116 +++++++++++
 rtl/uart_cpld_responder.sv | 181 ++++++++++++++++++
 tb/tb_uart_cpld_responder.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART responder that stands in for the external UART chip.
package uart_pkg;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    localparam int unsigned StatusDataReady = 0;
    localparam int unsigned StatusTbre      = 1;
    localparam int unsigned StatusTsre      = 2;
    localparam int unsigned StatusWidth     = 3;

    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_cpld_responder_if.sv
// Memory-unit side of the UART: strobes, shared low data byte and status flags.
interface uart_cpld_responder_if;

    logic       uart_rdn;
    logic       uart_wrn;
    logic [7:0] bus_data_in;
    logic [7:0] bus_data_out;
    logic       bus_data_oe;
    logic       uart_dataready;
    logic       uart_tbre;
    logic       uart_tsre;

    modport master (
        output uart_rdn, uart_wrn, bus_data_in,
        input  bus_data_out, bus_data_oe, uart_dataready, uart_tbre, uart_tsre
    );

    modport slave (
        input  uart_rdn, uart_wrn, bus_data_in,
        output bus_data_out, bus_data_oe, uart_dataready, uart_tbre, uart_tsre
    );

endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 receiver: synchronises rxd, finds the start bit, samples bit centres and owns the rx holding
// register with its dataready/overrun flags.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV    = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       read_clr,
    output logic [7:0] rx_hold,
    output logic       dataready,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int unsigned     CntW    = $clog2(BAUD_DIV);
    localparam logic [CntW-1:0] LastCnt = CntW'(BAUD_DIV - 1);
    localparam logic [CntW-1:0] HalfCnt = CntW'(BAUD_DIV / 2 - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s, rxd_prev_q;
    rx_state_e              state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d, hold_q, hold_d;
    logic                   dr_q, dr_d, ov_q, ov_d, ferr_q, ferr_d;
    logic                   stop_ok, stop_bad;

    assign rxd_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '1;
            rxd_prev_q <= 1'b1;
            state_q    <= RxIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            dr_q       <= 1'b0;
            ov_q       <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rxd};
            rxd_prev_q <= rxd_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            dr_q       <= dr_d;
            ov_q       <= ov_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        unique case (state_q)
            RxIdle: begin
                cnt_d = '0;
                if (rxd_prev_q && !rxd_s) state_d = RxStart;
            end
            RxStart: if (cnt_q == HalfCnt) begin
                // Line back high at mid start bit means it was only a glitch.
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rxd_s ? RxIdle : RxData;
            end
            RxData: if (cnt_q == LastCnt) begin
                cnt_d   = '0;
                shift_d = {rxd_s, shift_q[7:1]};
                bit_d   = bit_q + 1'b1;
                if (bit_q == 3'd7) state_d = RxStop;
            end
            RxStop: if (cnt_q == LastCnt) begin
                cnt_d    = '0;
                state_d  = RxIdle;
                stop_ok  = rxd_s;
                stop_bad = !rxd_s;
            end
            default: state_d = RxIdle;
        endcase
    end

    // A read ending in the same cycle as a good stop bit clears first, so the new byte is not an overrun.
    always_comb begin
        hold_d = hold_q;
        dr_d   = dr_q;
        ov_d   = ov_q;
        if (read_clr) begin
            dr_d = 1'b0;
            ov_d = 1'b0;
        end
        if (stop_ok) begin
            hold_d = shift_q;
            ov_d   = ov_d | dr_d;
            dr_d   = 1'b1;
        end
        ferr_d = stop_bad;
    end

    assign rx_hold      = hold_q;
    assign dataready    = dr_q;
    assign rx_overrun   = ov_q;
    assign rx_frame_err = ferr_q;

endmodule

// File: rtl/uart_cpld_responder.sv
// UART responder on the memory unit's rdn/wrn strobes and shared low data byte; owns the strobe
// handling and the 8N1 transmitter, and instantiates the receiver.
module uart_cpld_responder
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned BAUD        = 9_600,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_cpld_responder_if.slave  bus,
    output logic                  txd,
    input  logic                  rxd,
    output logic                  rx_overrun,
    output logic                  rx_frame_err
);

    localparam int unsigned     BaudDiv = baud_div(CLK_HZ, BAUD);
    localparam int unsigned     CntW    = $clog2(BaudDiv);
    localparam logic [CntW-1:0] LastCnt = CntW'(BaudDiv - 1);

    logic [SYNC_STAGES-1:0]      rdn_sync_q, wrn_sync_q;
    logic [SYNC_STAGES-1:0][7:0] data_sync_q;
    logic                        rdn_s, wrn_s, rdn_prev_q, wrn_prev_q;
    logic                        rd_fall, rd_rise, wr_rise, wr_accept;
    logic                        oe_q, wr_ovl_q;
    logic [7:0]                  out_q, tx_hold_q, rx_hold;
    logic                        dataready;

    tx_state_e                   tx_state_q, tx_state_d;
    logic [CntW-1:0]             tx_cnt_q, tx_cnt_d;
    logic [2:0]                  tx_bit_q, tx_bit_d;
    logic [7:0]                  tx_shift_q, tx_shift_d;
    logic                        tbre_q, tbre_d, tsre_q, tsre_d, txd_q, txd_d;
    logic                        tx_load, tx_done;
    logic [StatusWidth-1:0]      status;

    assign rdn_s     = rdn_sync_q[SYNC_STAGES-1];
    assign wrn_s     = wrn_sync_q[SYNC_STAGES-1];
    assign rd_fall   = rdn_prev_q & ~rdn_s;
    assign rd_rise   = ~rdn_prev_q & rdn_s;
    assign wr_rise   = ~wrn_prev_q & wrn_s;
    assign wr_accept = wr_rise & ~wr_ovl_q & tbre_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdn_sync_q  <= '1;
            wrn_sync_q  <= '1;
            data_sync_q <= '0;
            rdn_prev_q  <= 1'b1;
            wrn_prev_q  <= 1'b1;
            oe_q        <= 1'b0;
            out_q       <= '0;
            wr_ovl_q    <= 1'b0;
            tx_hold_q   <= '0;
        end else begin
            rdn_sync_q  <= {rdn_sync_q[SYNC_STAGES-2:0], bus.uart_rdn};
            wrn_sync_q  <= {wrn_sync_q[SYNC_STAGES-2:0], bus.uart_wrn};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.bus_data_in};
            rdn_prev_q  <= rdn_s;
            wrn_prev_q  <= wrn_s;
            if (rd_fall) begin
                oe_q  <= 1'b1;
                out_q <= rx_hold;
            end else if (rd_rise) begin
                oe_q <= 1'b0;
            end
            // Any overlap with a read poisons the write strobe until its rising edge.
            if (wr_rise) wr_ovl_q <= 1'b0;
            else if (!wrn_s && !rdn_s) wr_ovl_q <= 1'b1;
            if (wr_accept) tx_hold_q <= data_sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tbre_q     <= 1'b1;
            tsre_q     <= 1'b1;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tbre_q     <= tbre_d;
            tsre_q     <= tsre_d;
            txd_q      <= txd_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_load    = 1'b0;
        tx_done    = 1'b0;
        unique case (tx_state_q)
            TxIdle: begin
                tx_cnt_d = '0;
                if (!tbre_q) begin
                    tx_state_d = TxStart;
                    tx_shift_d = tx_hold_q;
                    tx_load    = 1'b1;
                end
            end
            TxStart: if (tx_cnt_q == LastCnt) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_state_d = TxData;
            end
            TxData: if (tx_cnt_q == LastCnt) begin
                tx_cnt_d   = '0;
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_bit_d   = tx_bit_q + 1'b1;
                if (tx_bit_q == 3'd7) tx_state_d = TxStop;
            end
            TxStop: if (tx_cnt_q == LastCnt) begin
                tx_cnt_d = '0;
                // A pending byte starts straight away with no idle gap.
                if (!tbre_q) begin
                    tx_state_d = TxStart;
                    tx_shift_d = tx_hold_q;
                    tx_load    = 1'b1;
                end else begin
                    tx_state_d = TxIdle;
                    tx_done    = 1'b1;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_comb begin
        tbre_d = tbre_q;
        if (tx_load) tbre_d = 1'b1;
        else if (wr_accept) tbre_d = 1'b0;
        tsre_d = tsre_q;
        if (tx_load) tsre_d = 1'b0;
        else if (tx_done) tsre_d = 1'b1;
        unique case (tx_state_d)
            TxStart: txd_d = 1'b0;
            TxData:  txd_d = tx_shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    uart_rx_deserializer #(
        .BAUD_DIV    (BaudDiv),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .rxd          (rxd),
        .read_clr     (rd_rise),
        .rx_hold      (rx_hold),
        .dataready    (dataready),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    always_comb begin
        status                  = '0;
        status[StatusDataReady] = dataready;
        status[StatusTbre]      = tbre_q;
        status[StatusTsre]      = tsre_q;
    end

    assign bus.uart_dataready = status[StatusDataReady];
    assign bus.uart_tbre      = status[StatusTbre];
    assign bus.uart_tsre      = status[StatusTsre];
    assign bus.bus_data_oe    = oe_q;
    assign bus.bus_data_out   = out_q;
    assign txd                = txd_q;

endmodule

// File: tb/tb_uart_cpld_responder.sv
// Bench for uart_cpld_responder: random bytes in both directions against a frame-level model.
module tb_uart_cpld_responder;

    localparam int unsigned ClkHz   = 1_000_000;
    localparam int unsigned Baud    = 100_000;
    localparam int          BitClks = ClkHz / Baud;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rxd = 1'b1;
    logic txd, rx_overrun, rx_frame_err;

    uart_cpld_responder_if bus_if ();

    uart_cpld_responder #(
        .CLK_HZ      (ClkHz),
        .BAUD        (Baud),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_if),
        .txd          (txd),
        .rxd          (rxd),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int ferr_count = 0;

    // Receive-side model: what the holding register and flags should hold.
    logic [7:0] m_hold = 8'h00;
    logic       m_dr = 1'b0;
    logic       m_ov = 1'b0;

    logic [7:0] b1, b2, rnd;
    logic       s1, s2;
    int         g1, g2, lows, f0;

    always @(negedge clk) if (rx_frame_err === 1'b1) ferr_count++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus_if.bus_data_in = b;
        @(negedge clk);
        bus_if.uart_wrn = 1'b0;
        wait_clks(4);
        bus_if.uart_wrn = 1'b1;
        wait_clks(4);
    endtask

    task automatic read_check(input string tag);
        bus_if.uart_rdn = 1'b0;
        wait_clks(4);
        check_eq({tag, "_oe"}, 32'(bus_if.bus_data_oe), 1);
        check_eq({tag, "_data"}, 32'(bus_if.bus_data_out), 32'(m_hold));
        bus_if.uart_rdn = 1'b1;
        wait_clks(4);
        m_dr = 1'b0;
        m_ov = 1'b0;
        check_eq({tag, "_oe_off"}, 32'(bus_if.bus_data_oe), 0);
        check_eq({tag, "_dr_clr"}, 32'(bus_if.uart_dataready), 0);
        check_eq({tag, "_ov_clr"}, 32'(rx_overrun), 0);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = frame[i];
            wait_clks(BitClks);
        end
        rxd = 1'b1;
        if (stop) begin
            m_ov   = m_ov | m_dr;
            m_dr   = 1'b1;
            m_hold = b;
        end
    endtask

    // Returns after sampling the middle of the stop bit; gap counts clocks waited for the start bit.
    task automatic capture_tx(output logic [7:0] b, output logic stop, output int gap);
        logic [9:0] f;
        gap = 0;
        while (txd !== 1'b0 && gap < 400) begin
            @(negedge clk);
            gap++;
        end
        check_eq("tx_start_seen", 32'(txd), 0);
        wait_clks(BitClks / 2);
        for (int i = 0; i < 10; i++) begin
            f[i] = txd;
            if (i < 9) wait_clks(BitClks);
        end
        check_eq("tx_start_mid", 32'(f[0]), 0);
        b    = f[8:1];
        stop = f[9];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus_if.uart_rdn    = 1'b1;
        bus_if.uart_wrn    = 1'b1;
        bus_if.bus_data_in = 8'h00;

        #2 rst_n = 1'b0;
        wait_clks(3);
        check_eq("rst_txd", 32'(txd), 1);
        check_eq("rst_tbre", 32'(bus_if.uart_tbre), 1);
        check_eq("rst_tsre", 32'(bus_if.uart_tsre), 1);
        check_eq("rst_dr", 32'(bus_if.uart_dataready), 0);
        check_eq("rst_oe", 32'(bus_if.bus_data_oe), 0);
        check_eq("rst_out", 32'(bus_if.bus_data_out), 0);
        check_eq("rst_ov", 32'(rx_overrun), 0);
        check_eq("rst_ferr", 32'(rx_frame_err), 0);
        rst_n = 1'b1;
        wait_clks(2);

        // Reset in the middle of a start bit.
        write_byte(8'($urandom));
        g1 = 0;
        while (txd !== 1'b0 && g1 < 50) begin
            @(negedge clk);
            g1++;
        end
        wait_clks(2);
        check_eq("pre_rst_txd_low", 32'(txd), 0);
        #2 rst_n = 1'b0;
        #1 check_eq("rst_txd_immediate", 32'(txd), 1);
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(2);
        check_eq("post_rst_tbre", 32'(bus_if.uart_tbre), 1);
        check_eq("post_rst_tsre", 32'(bus_if.uart_tsre), 1);
        check_eq("post_rst_dr", 32'(bus_if.uart_dataready), 0);
        wait_clks(150);
        check_eq("post_rst_line_idle", 32'(bus_if.uart_tsre), 1);

        // Single frame with exact line-idle timing.
        write_byte(8'hA5);
        capture_tx(b1, s1, g1);
        check_eq("tx_a5_byte", 32'(b1), 32'hA5);
        check_eq("tx_a5_stop", 32'(s1), 1);
        wait_clks(4);
        check_eq("tx_a5_tsre_busy", 32'(bus_if.uart_tsre), 0);
        wait_clks(1);
        check_eq("tx_a5_tsre_done", 32'(bus_if.uart_tsre), 1);

        for (int k = 0; k < 3; k++) begin
            rnd = 8'($urandom);
            write_byte(rnd);
            capture_tx(b1, s1, g1);
            check_eq("tx_rand_byte", 32'(b1), 32'(rnd));
            check_eq("tx_rand_stop", 32'(s1), 1);
            wait_clks(10);
        end

        // Back-to-back frames; a third write while the holding register is full is dropped.
        fork
            begin
                capture_tx(b1, s1, g1);
                capture_tx(b2, s2, g2);
                check_eq("b2b_first", 32'(b1), 32'h55);
                check_eq("b2b_second", 32'(b2), 32'h0F);
                check_eq("b2b_stops", 32'({s1, s2}), 3);
                check_eq("b2b_no_gap", 32'(g2), 32'(BitClks / 2));
                lows = 0;
                for (int i = 0; i < 300; i++) begin
                    @(negedge clk);
                    if (txd === 1'b0) lows++;
                end
                check_eq("b2b_third_dropped", 32'(lows), 0);
                check_eq("b2b_tbre_end", 32'(bus_if.uart_tbre), 1);
            end
            begin
                write_byte(8'h55);
                wait_clks(10);
                write_byte(8'h0F);
                wait_clks(2);
                check_eq("b2b_tbre_full", 32'(bus_if.uart_tbre), 0);
                write_byte(8'hC3 ^ 8'($urandom_range(7, 0)));
            end
        join

        // Receive and read back.
        send_rx(8'h3C, 1'b1);
        wait_clks(3);
        check_eq("rx_3c_dr", 32'(bus_if.uart_dataready), 32'(m_dr));
        read_check("rx_3c_read");

        // Overrun: second byte overwrites and sets the sticky flag.
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        wait_clks(3);
        check_eq("ovr_flag", 32'(rx_overrun), 32'(m_ov));
        check_eq("ovr_dr", 32'(bus_if.uart_dataready), 32'(m_dr));
        read_check("ovr_read");

        // Framing error keeps the previous byte and dataready.
        rnd = 8'($urandom);
        send_rx(rnd, 1'b1);
        f0 = ferr_count;
        send_rx(8'($urandom), 1'b0);
        wait_clks(3);
        check_eq("ferr_pulses", 32'(ferr_count - f0), 1);
        check_eq("ferr_dr_kept", 32'(bus_if.uart_dataready), 32'(m_dr));
        check_eq("ferr_no_ovr", 32'(rx_overrun), 32'(m_ov));
        read_check("ferr_read");

        // Short low glitch must not start a frame.
        f0 = ferr_count;
        rxd = 1'b0;
        wait_clks(3);
        rxd = 1'b1;
        wait_clks(150);
        check_eq("glitch_dr", 32'(bus_if.uart_dataready), 32'(m_dr));
        check_eq("glitch_ferr", 32'(ferr_count - f0), 0);

        // Simultaneous read and write: the read is serviced and the write ignored.
        bus_if.bus_data_in = 8'($urandom);
        bus_if.uart_rdn    = 1'b0;
        bus_if.uart_wrn    = 1'b0;
        wait_clks(4);
        bus_if.uart_wrn = 1'b1;
        wait_clks(12);
        check_eq("rdwr_oe", 32'(bus_if.bus_data_oe), 1);
        check_eq("rdwr_tsre", 32'(bus_if.uart_tsre), 1);
        check_eq("rdwr_tbre", 32'(bus_if.uart_tbre), 1);
        bus_if.uart_rdn = 1'b1;
        wait_clks(4);
        m_dr = 1'b0;
        m_ov = 1'b0;
        check_eq("rdwr_oe_off", 32'(bus_if.bus_data_oe), 0);

        // Random receive traffic with random reads.
        f0 = ferr_count;
        for (int k = 0; k < 6; k++) begin
            send_rx(8'($urandom), 1'b1);
            wait_clks(3);
            check_eq("rnd_rx_dr", 32'(bus_if.uart_dataready), 32'(m_dr));
            check_eq("rnd_rx_ov", 32'(rx_overrun), 32'(m_ov));
            if ($urandom_range(1, 0) == 1) read_check("rnd_rx_read");
        end
        check_eq("rnd_rx_no_ferr", 32'(ferr_count - f0), 0);
        read_check("final_read");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
